// File: rtl/pe_load_store_unit_if.sv
// Request, memory and response bundle for the PE load/store unit.
// master = PE/memory side, slave = the load/store unit.
interface pe_load_store_unit_if #(
    parameter int XLEN = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_store;
    logic [2:0]        req_funct3;
    logic [XLEN-1:0]   req_base;
    logic [11:0]       req_imm;
    logic [XLEN-1:0]   req_wdata;
    logic [4:0]        req_rd;
    logic [XLEN-1:0]   mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [XLEN-1:0]   mem_wdata;
    logic [XLEN/8-1:0] mem_wstrb;
    logic [XLEN-1:0]   mem_rdata;
    logic              mem_ack;
    logic              resp_valid;
    logic              resp_ready;
    logic [XLEN-1:0]   resp_data;
    logic [4:0]        resp_rd;
    logic              resp_rdWrite;
    logic              resp_fault;
    logic [1:0]        fault_cause;

    modport master (
        output req_valid, req_store, req_funct3, req_base,
        output req_imm, req_wdata, req_rd,
        output mem_rdata, mem_ack, resp_ready,
        input  req_ready, mem_address, mem_read, mem_write,
        input  mem_wdata, mem_wstrb, resp_valid, resp_data,
        input  resp_rd, resp_rdWrite, resp_fault, fault_cause
    );

    modport slave (
        input  req_valid, req_store, req_funct3, req_base,
        input  req_imm, req_wdata, req_rd,
        input  mem_rdata, mem_ack, resp_ready,
        output req_ready, mem_address, mem_read, mem_write,
        output mem_wdata, mem_wstrb, resp_valid, resp_data,
        output resp_rd, resp_rdWrite, resp_fault, fault_cause
    );
endinterface

// File: rtl/pe_load_store_unit.sv
// Load/store unit for a CGRA RISC-V PE: one request/ack memory
// transaction per accepted op, returning extended data or a fault.
module pe_load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 reset,
    pe_load_store_unit_if.slave bus
);
    localparam int NB   = XLEN / 8;
    localparam int LW   = $clog2(NB);
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_e;

    state_e          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [NB-1:0]   wstrb_q, wstrb_d;
    logic            read_q, read_d;
    logic            write_q, write_d;
    logic [2:0]      f3_q, f3_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] rdat_q, rdat_d;
    logic            rdw_q, rdw_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [4:0]      rrd_q, rrd_d;

    logic [XLEN-1:0] ea, wrep, shifted, ext;
    logic [LW-1:0]   lane;
    logic [3:0]      nbytes;
    logic [15:0]     bmask;
    logic            legal, misal, accept, expire, leave;

    assign ea     = bus.req_base + XLEN'($signed(bus.req_imm));
    assign lane   = ea[LW-1:0];
    assign nbytes = 4'd1 << bus.req_funct3[1:0];
    assign bmask  = (16'd1 << nbytes) - 16'd1;
    assign misal  = |(ea[2:0] & 3'(nbytes - 4'd1));
    assign accept = bus.req_valid && bus.req_ready;
    assign expire = (TIMEOUT != 0) &&
                    (32'(cnt_q) + 32'd1 == 32'(TIMEOUT));

    always_comb begin
        legal = 1'b0;
        unique case (bus.req_funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b011:         legal = (XLEN == 64);
            3'b100, 3'b101: legal = !bus.req_store;
            3'b110:         legal = (XLEN == 64) && !bus.req_store;
            default:        legal = 1'b0;
        endcase
    end

    always_comb begin
        wrep = bus.req_wdata;
        unique case (bus.req_funct3[1:0])
            2'b00:   wrep = {NB{bus.req_wdata[7:0]}};
            2'b01:   wrep = {(NB/2){bus.req_wdata[15:0]}};
            2'b10:   wrep = {(NB/4){bus.req_wdata[31:0]}};
            default: wrep = bus.req_wdata;
        endcase
    end

    // Load lane selected by the low EA bits captured at accept
    assign shifted = bus.mem_rdata >> {lane_q, 3'b000};

    always_comb begin
        ext = shifted;
        unique case (f3_q)
            3'b000:  ext = XLEN'($signed(shifted[7:0]));
            3'b001:  ext = XLEN'($signed(shifted[15:0]));
            3'b010:  ext = XLEN'($signed(shifted[31:0]));
            3'b100:  ext = XLEN'(shifted[7:0]);
            3'b101:  ext = XLEN'(shifted[15:0]);
            3'b110:  ext = XLEN'(shifted[31:0]);
            default: ext = shifted;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        read_d  = read_q;
        write_d = write_q;
        f3_d    = f3_q;
        lane_d  = lane_q;
        rd_d    = rd_q;
        rdat_d  = rdat_q;
        rdw_d   = rdw_q;
        fault_d = fault_q;
        cause_d = cause_q;
        rrd_d   = rrd_q;
        leave   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    f3_d   = bus.req_funct3;
                    lane_d = lane;
                    rd_d   = bus.req_rd;
                    if (!legal || misal) begin
                        state_d = S_RESP;
                        fault_d = 1'b1;
                        cause_d = legal ? 2'b01 : 2'b11;
                        rrd_d   = bus.req_rd;
                        rdat_d  = '0;
                        rdw_d   = 1'b0;
                    end else begin
                        state_d = S_ACCESS;
                        cnt_d   = '0;
                        addr_d  = {ea[XLEN-1:LW], {LW{1'b0}}};
                        read_d  = !bus.req_store;
                        write_d = bus.req_store;
                        wdata_d = bus.req_store ? wrep : '0;
                        wstrb_d = bus.req_store ?
                                  (bmask[NB-1:0] << lane) : '0;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.mem_ack) begin
                    leave   = 1'b1;
                    rdw_d   = read_q;
                    rdat_d  = read_q ? ext : '0;
                    fault_d = 1'b0;
                    cause_d = 2'b00;
                end else if (expire) begin
                    leave   = 1'b1;
                    rdw_d   = 1'b0;
                    rdat_d  = '0;
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
                if (leave) begin
                    state_d = S_RESP;
                    rrd_d   = rd_q;
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    wstrb_d = '0;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d = S_IDLE;
                    rdat_d  = '0;
                    rdw_d   = 1'b0;
                    fault_d = 1'b0;
                    cause_d = 2'b00;
                    rrd_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            f3_q    <= '0;
            lane_q  <= '0;
            rd_q    <= '0;
            rdat_q  <= '0;
            rdw_q   <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= '0;
            rrd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            read_q  <= read_d;
            write_q <= write_d;
            f3_q    <= f3_d;
            lane_q  <= lane_d;
            rd_q    <= rd_d;
            rdat_q  <= rdat_d;
            rdw_q   <= rdw_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
            rrd_q   <= rrd_d;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE) && reset;
    assign bus.mem_address  = addr_q;
    assign bus.mem_read     = read_q;
    assign bus.mem_write    = write_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_wstrb    = wstrb_q;
    assign bus.resp_valid   = (state_q == S_RESP);
    assign bus.resp_data    = rdat_q;
    assign bus.resp_rd      = rrd_q;
    assign bus.resp_rdWrite = rdw_q;
    assign bus.resp_fault   = fault_q;
    assign bus.fault_cause  = cause_q;
endmodule

// File: tb/tb_pe_load_store_unit.sv
// Bench for pe_load_store_unit: XLEN=32/TIMEOUT=4 and XLEN=64/TIMEOUT=0
// instances driven from one stimulus set, checked against a byte-level model.
module tb_pe_load_store_unit;
    localparam int TO_A = 4;
    localparam int TO_B = 0;

    logic        clk;
    logic        rst_n;
    logic        sel;
    logic        v, st, ack, rr;
    logic [2:0]  f3;
    logic [63:0] base, wd, rdat;
    logic [11:0] imm;
    logic [4:0]  rd;

    int n_chk = 0;
    int n_fail = 0;

    logic [63:0] last_data, last_addr, last_wdata;
    logic [7:0]  last_strb;
    logic [4:0]  last_rd;
    logic        last_rdw, last_fault;
    logic [1:0]  last_cause;
    int          last_nhi, last_lat;

    pe_load_store_unit_if #(.XLEN(32)) ia ();
    pe_load_store_unit_if #(.XLEN(64)) ib ();

    pe_load_store_unit #(.XLEN(32), .TIMEOUT(TO_A)) u_a (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ia)
    );

    pe_load_store_unit #(.XLEN(64), .TIMEOUT(TO_B)) u_b (
        .clk   (clk),
        .reset (rst_n),
        .bus   (ib)
    );

    assign ia.req_valid  = v & ~sel;
    assign ia.req_store  = st;
    assign ia.req_funct3 = f3;
    assign ia.req_base   = base[31:0];
    assign ia.req_imm    = imm;
    assign ia.req_wdata  = wd[31:0];
    assign ia.req_rd     = rd;
    assign ia.mem_rdata  = rdat[31:0];
    assign ia.mem_ack    = ack & ~sel;
    assign ia.resp_ready = rr;

    assign ib.req_valid  = v & sel;
    assign ib.req_store  = st;
    assign ib.req_funct3 = f3;
    assign ib.req_base   = base;
    assign ib.req_imm    = imm;
    assign ib.req_wdata  = wd;
    assign ib.req_rd     = rd;
    assign ib.mem_rdata  = rdat;
    assign ib.mem_ack    = ack & sel;
    assign ib.resp_ready = rr;

    logic        o_rdy, o_rd, o_wr, o_rv, o_rdw, o_flt;
    logic [63:0] o_addr, o_wdata, o_rdata;
    logic [7:0]  o_strb;
    logic [4:0]  o_rrd;
    logic [1:0]  o_cause;

    assign o_rdy   = sel ? ib.req_ready : ia.req_ready;
    assign o_rd    = sel ? ib.mem_read : ia.mem_read;
    assign o_wr    = sel ? ib.mem_write : ia.mem_write;
    assign o_rv    = sel ? ib.resp_valid : ia.resp_valid;
    assign o_rdw   = sel ? ib.resp_rdWrite : ia.resp_rdWrite;
    assign o_flt   = sel ? ib.resp_fault : ia.resp_fault;
    assign o_addr  = sel ? ib.mem_address : {32'd0, ia.mem_address};
    assign o_wdata = sel ? ib.mem_wdata : {32'd0, ia.mem_wdata};
    assign o_rdata = sel ? ib.resp_data : {32'd0, ia.resp_data};
    assign o_strb  = sel ? ib.mem_wstrb : {4'd0, ia.mem_wstrb};
    assign o_rrd   = sel ? ib.resp_rd : ia.resp_rd;
    assign o_cause = sel ? ib.fault_cause : ia.fault_cause;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Byte-level view: EA, size, lane, and the bytes that move
    task automatic model(
        input  int          xl,
        input  logic        st_i,
        input  logic [2:0]  f3_i,
        input  logic [63:0] base_i,
        input  logic [11:0] imm_i,
        input  logic [63:0] wd_i,
        input  logic [63:0] rdat_i,
        output logic        lg,
        output logic        ms,
        output logic [63:0] e_addr,
        output logic [63:0] e_wdata,
        output logic [7:0]  e_strb,
        output logic [63:0] e_data
    );
        logic [63:0] m, ea, szm, val, wv, rv;
        int nb, sz, lane;
        m    = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        nb   = xl / 8;
        sz   = 1 << f3_i[1:0];
        ea   = (base_i + {{52{imm_i[11]}}, imm_i}) & m;
        wv   = wd_i & m;
        rv   = rdat_i & m;
        if (f3_i <= 3'd2)       lg = 1'b1;
        else if (f3_i == 3'd3)  lg = (xl == 64);
        else if (f3_i <= 3'd5)  lg = !st_i;
        else if (f3_i == 3'd6)  lg = (xl == 64) && !st_i;
        else                    lg = 1'b0;
        ms     = (ea % sz) != 0;
        lane   = int'(ea % nb);
        e_addr = ea - 64'(lane);
        szm    = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF :
                 ((64'd1 << (8 * sz)) - 64'd1);
        e_strb = 8'(((1 << sz) - 1) << lane);
        e_wdata = 64'd0;
        for (int i = 0; i < nb / sz; i++)
            e_wdata = e_wdata | ((wv & szm) << (8 * sz * i));
        if (!st_i) begin
            e_strb  = 8'd0;
            e_wdata = 64'd0;
        end
        val = (rv >> (8 * lane)) & szm;
        if (!f3_i[2] && val[8*sz-1]) val = val | ~szm;
        e_data = val & m;
    endtask

    task automatic do_op(
        input logic        s,
        input logic        st_i,
        input logic [2:0]  f3_i,
        input logic [63:0] base_i,
        input logic [11:0] imm_i,
        input logic [63:0] wd_i,
        input logic [63:0] rdat_i,
        input logic [4:0]  rd_i,
        input int          d,
        input int          stall
    );
        int xl, to, lat, nhi, exp_lat;
        logic lg, ms, ok, tmo, exp_rdw;
        logic [63:0] e_addr, e_wdata, e_data, e_resp;
        logic [7:0]  e_strb;
        logic [1:0]  e_cause;
        xl = s ? 64 : 32;
        to = s ? TO_B : TO_A;
        model(xl, st_i, f3_i, base_i, imm_i, wd_i, rdat_i,
              lg, ms, e_addr, e_wdata, e_strb, e_data);
        ok      = lg && !ms;
        tmo     = ok && (to != 0) && (d >= to);
        exp_rdw = ok && !tmo && !st_i;
        e_resp  = exp_rdw ? e_data : 64'd0;
        e_cause = !lg ? 2'd3 : ms ? 2'd1 : tmo ? 2'd2 : 2'd0;
        exp_lat = !ok ? 0 : tmo ? to : d + 1;

        sel = s;
        #1;
        chk("req_ready", 64'(o_rdy), 64'd1);
        v = 1'b1; st = st_i; f3 = f3_i; base = base_i;
        imm = imm_i; wd = wd_i; rdat = rdat_i; rd = rd_i;
        @(posedge clk);
        #1;
        v = 1'b0;
        lat = 0;
        nhi = 0;
        while (!o_rv && lat < 64) begin
            if (o_rd || o_wr) nhi++;
            if (lat == 0) begin
                chk("mem_read", 64'(o_rd), 64'(!st_i));
                chk("mem_write", 64'(o_wr), 64'(st_i));
                chk("mem_wstrb", 64'(o_strb), 64'(e_strb));
                chk("mem_wdata", o_wdata, e_wdata);
                last_strb  = o_strb;
                last_wdata = o_wdata;
                last_addr  = o_addr;
            end
            if (o_rd || o_wr) chk("mem_address", o_addr, e_addr);
            ack = (lat == d);
            @(posedge clk);
            #1;
            ack = 1'b0;
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("bus_cycles", 64'(nhi), ok ? 64'(exp_lat) : 64'd0);
        last_nhi = nhi;
        last_lat = lat;

        // A stray ack while the response waits must change nothing
        ack = 1'b1;
        for (int i = 0; i <= stall; i++) begin
            chk("resp_valid", 64'(o_rv), 64'd1);
            chk("resp_data", o_rdata, e_resp);
            chk("resp_rd", 64'(o_rrd), 64'(rd_i));
            chk("resp_rdWrite", 64'(o_rdw), 64'(exp_rdw));
            chk("resp_fault", 64'(o_flt), 64'(!ok || tmo));
            chk("fault_cause", 64'(o_cause), 64'(e_cause));
            chk("req_ready_busy", 64'(o_rdy), 64'd0);
            chk("bus_idle", 64'({o_rd, o_wr}), 64'd0);
            if (i == 0) begin
                last_data  = o_rdata;
                last_rd    = o_rrd;
                last_rdw   = o_rdw;
                last_fault = o_flt;
                last_cause = o_cause;
            end
            if (i == stall) rr = 1'b1;
            @(posedge clk);
            #1;
            ack = 1'b0;
        end
        rr = 1'b0;
        chk("resp_done", 64'(o_rv), 64'd0);
        chk("req_ready_back", 64'(o_rdy), 64'd1);
        chk("bus_idle_after", 64'({o_rd, o_wr}), 64'd0);
    endtask

    initial begin
        logic [63:0] rb, rw, rx;
        logic [11:0] ri;
        logic        rs;
        rst_n = 1'b0;
        sel = 1'b0; v = 1'b0; st = 1'b0; ack = 1'b0; rr = 1'b0;
        f3 = 3'd0; base = '0; wd = '0; rdat = '0; imm = '0; rd = '0;
        #2;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_req_ready", 64'(o_rdy), 64'd0);
            chk("rst_resp_valid", 64'(o_rv), 64'd0);
            chk("rst_mem", 64'({o_rd, o_wr}), 64'd0);
            chk("rst_addr", o_addr, 64'd0);
            chk("rst_resp", 64'({o_flt, o_cause, o_rdw}), 64'd0);
        end
        #9;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sel = 1'b0;
        #1;
        chk("rdy_after_rst", 64'(o_rdy), 64'd1);

        // LH sign extension, ack after 2 cycles
        do_op(0, 0, 3'b001, 64'h25, 12'h023, 0, 64'h80A5, 5'd23, 2, 0);
        chk("T1_data", last_data, 64'hFFFF_80A5);
        chk("T1_rdw", 64'(last_rdw), 64'd1);
        chk("T1_rd", 64'(last_rd), 64'd23);
        chk("T1_addr", last_addr, 64'h48);

        do_op(0, 0, 3'b100, 64'h100, 12'h003, 0, 64'hA500_0000, 5'd4, 0, 1);
        chk("T2_addr", last_addr, 64'h100);
        chk("T2_data", last_data, 64'hA5);

        do_op(0, 1, 3'b001, 64'h100, 12'h002, 64'h1234_BEEF, 0, 5'd9, 3, 0);
        chk("T3_addr", last_addr, 64'h100);
        chk("T3_strb", 64'(last_strb), 64'hC);
        chk("T3_wdata", last_wdata, 64'hBEEF_BEEF);
        chk("T3_rdw", 64'(last_rdw), 64'd0);
        chk("T3_cycles", 64'(last_nhi), 64'd4);

        do_op(0, 0, 3'b010, 64'h40, 12'h001, 0, 0, 5'd7, 0, 0);
        chk("T4_cause", 64'(last_cause), 64'd1);
        chk("T4_lat", 64'(last_lat), 64'd0);
        chk("T4_cycles", 64'(last_nhi), 64'd0);
        do_op(0, 0, 3'b111, 64'h40, 12'h000, 0, 0, 5'd7, 0, 0);
        chk("T4_illegal", 64'(last_cause), 64'd3);
        do_op(0, 1, 3'b100, 64'h40, 12'h000, 0, 0, 5'd7, 0, 0);
        chk("T4_store_bu", 64'(last_cause), 64'd3);
        do_op(0, 0, 3'b011, 64'h40, 12'h000, 0, 0, 5'd7, 0, 0);
        chk("T4_ld_on_32", 64'(last_cause), 64'd3);

        do_op(0, 0, 3'b010, 64'h80, 12'h000, 0, 64'h55, 5'd3, 9, 0);
        chk("T5_cause", 64'(last_cause), 64'd2);
        chk("T5_cycles", 64'(last_nhi), 64'd4);
        chk("T5_data", last_data, 64'd0);
        do_op(0, 0, 3'b010, 64'h80, 12'h000, 0, 64'h55, 5'd3, 3, 0);
        chk("T5_ack_last", last_data, 64'h55);

        do_op(0, 0, 3'b010, 64'h1000, 12'hFFC, 0, 64'hCAFE, 5'd30, 1, 3);
        chk("T6_negimm", last_addr, 64'hFFC);
        do_op(0, 0, 3'b000, 64'hFFFF_FFFF, 12'h001, 0, 64'h81, 5'd2, 0, 0);
        chk("wrap_addr", last_addr, 64'h0);
        chk("wrap_data", last_data, 64'hFFFF_FF81);

        // Reset pulse in the middle of an access
        sel = 1'b0;
        #1;
        v = 1'b1; st = 1'b0; f3 = 3'b010; base = 64'h200;
        imm = 12'h0; rd = 5'd5;
        @(posedge clk);
        #1;
        v = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_read", 64'(o_rd), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_drop_read", 64'(o_rd), 64'd0);
        chk("rst_hold_ready", 64'(o_rdy), 64'd0);
        #2 rst_n = 1'b1;
        #1;
        chk("rst_release_ready", 64'(o_rdy), 64'd1);
        chk("rst_no_resp", 64'(o_rv), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_op_gone", 64'({o_rd, o_rv}), 64'd0);

        // XLEN=64, no timeout
        do_op(1, 0, 3'b011, 64'h1000, 12'h008, 0,
              64'h8123_4567_89AB_CDEF, 5'd11, 1, 0);
        chk("LD_data", last_data, 64'h8123_4567_89AB_CDEF);
        do_op(1, 0, 3'b110, 64'h1004, 12'h000, 0,
              64'h89AB_CDEF_0123_4567, 5'd12, 2, 0);
        chk("LWU_data", last_data, 64'h0000_0000_89AB_CDEF);
        do_op(1, 0, 3'b010, 64'h1004, 12'h000, 0,
              64'h89AB_CDEF_0123_4567, 5'd12, 2, 0);
        chk("LW64_data", last_data, 64'hFFFF_FFFF_89AB_CDEF);
        do_op(1, 1, 3'b010, 64'h1004, 12'h000, 64'h1122_3344_5566_7788,
              0, 5'd1, 0, 0);
        chk("SW64_strb", 64'(last_strb), 64'hF0);
        chk("SW64_wdata", last_wdata, 64'h5566_7788_5566_7788);
        do_op(1, 1, 3'b011, 64'h2000, 12'h000, 64'hDEAD_BEEF_0BAD_F00D,
              0, 5'd1, 20, 0);
        chk("SD_strb", 64'(last_strb), 64'hFF);
        chk("SD_no_timeout", 64'(last_fault), 64'd0);
        do_op(1, 0, 3'b101, 64'hFFFF_FFFF_FFFF_FFFF, 12'h001, 0,
              64'hFFFF, 5'd6, 0, 0);
        chk("wrap64_data", last_data, 64'hFFFF);

        for (int n = 0; n < 200; n++) begin
            rs = 1'($urandom_range(0, 1));
            rb = {$urandom, $urandom};
            ri = 12'($urandom);
            rw = {$urandom, $urandom};
            rx = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) begin
                rb[2:0] = 3'd0;
                ri[2:0] = 3'd0;
            end
            do_op(rs, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  rb, ri, rw, rx, 5'($urandom),
                  int'($urandom_range(0, rs ? 7 : 5)),
                  int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end expected end of test");
        $fatal(1, "watchdog");
    end
endmodule
